reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor to the 4x16 register file for the pipelined MIPS datapath.
- Configurable register count and data width.
- Two combinational read ports and one synchronous write port.
- Optional write-to-read bypass.
- Per-register scoreboard (busy bit): issue logic reserves a destination register, and writeback clears the reservation.
- Sits between decode/issue (read ports, reserve) and writeback (write port). Hazard logic stalls on busy1/busy2.

Parameters:
WIDTH, 16, data width of each register and of wd/rd1/rd2
NREGS, 4, number of architectural registers (>=2); address width AW = clog2(NREGS), derived localparam
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary storage

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
rr1  input  AW  read address, port 1
rr2  input  AW  read address, port 2
rd1  output  WIDTH  read data, port 1 (combinational)
rd2  output  WIDTH  read data, port 2 (combinational)
wr  input  AW  write address
wd  input  WIDTH  write data
regwrite  input  1  write enable, sampled at rising clock
rsv_en  input  1  reserve request: mark register rsv_addr busy
rsv_addr  input  AW  register to reserve
busy1  output  1  register rr1 has an outstanding producer (combinational)
busy2  output  1  register rr2 has an outstanding producer (combinational)
busy_count  output  AW+1  number of registers currently busy (registered)

Behaviour:
- Clocking and reset: one clock, `clock`. Synchronous active-high reset on `reset`. On reset:
  - all registers cleared to 0, scoreboard cleared, busy_count = 0.
  - therefore rd1 = rd2 = 0 and busy1 = busy2 = 0 in the cycle after reset.
  - reset has priority over a coincident write or reservation; the write/reserve is discarded, including mid-operation.
- Write: at a rising edge with regwrite=1, reg[wr] <= wd. The new value is visible on the read ports from the next cycle (BYPASS=0), or the same cycle (BYPASS=1).
- Write to register 0 when ZERO_REG=1: ignored; reads of register 0 return 0 regardless.
- Read: rd1 = reg[rr1], rd2 = reg[rr2]. Zero latency, pure combinational mux.
- Bypass (BYPASS=1): if regwrite=1 and wr==rrN (and not the zero register), rdN = wd in the same cycle. Both ports may hit simultaneously.
- Scoreboard, per register sb[i]:
  - next sb[i] = (sb[i] & ~(regwrite & wr==i)) | (rsv_en & rsv_addr==i).
  - Simultaneous write and reserve of the same register: reserve wins and sb stays 1. The write retires the older producer; the new reservation is a younger one.
  - Reserving an already-busy register: stays busy, no error.
  - Writing a non-busy register: legal; the data is written and sb stays 0.
  - With ZERO_REG=1, register 0 is never busy.
- busyN = sb[rrN] & ~(BYPASS & regwrite & wr==rrN). A bypass hit satisfies the dependency. A reservation made this cycle affects busyN from the next cycle only.
- busy_count: popcount of sb, registered, updated the same edge as sb. Range 0..NREGS, or 0..NREGS-1 when ZERO_REG=1.
- Out-of-range addresses (NREGS not a power of two):
  - reads return 0, busy = 0.
  - writes and reservations are ignored.
- No X propagation from storage after reset. Before the first reset, contents are undefined.

Decomposition:
- Shared package reg_file_pkg:
  - defaults for WIDTH and NREGS.
  - clog2 helper function.
  - ZERO_ADDR constant.
- One natural sub-module: rf_scoreboard. It holds the sb bits, the reserve/release logic and the busy_count popcount, and takes clock/reset.
- Storage, read muxes and bypass stay in reg_file_sb.

Test Plan:
1. Reset, then write 16'hA5A5 to r1, 16'h1234 to r2, 16'hFFFF to r3 with regwrite=1; read rr1=1, rr2=3 -> rd1=A5A5, rd2=FFFF. Writes with regwrite=0 and wd=16'h0F0F leave contents unchanged.
2. ZERO_REG=1: write wd=16'hDEAD to r0, rsv r0 -> rd1=0, busy1=0, busy_count=0.
3. BYPASS=1: regwrite=1, wr=2, wd=16'h00C3, rr1=rr2=2 in the same cycle -> rd1=rd2=00C3 that cycle. With BYPASS=0, the old value that cycle and 00C3 the next.
4. Reserve r3 -> next cycle busy1=1 (rr1=3), busy_count=1. Write r3 wd=16'h0042 -> same cycle busy1=0 (bypass), next cycle sb[3]=0, busy_count=0, rd1=0042.
5. Same-cycle write r2 and rsv r2 (r2 previously busy) -> next cycle busy stays 1, rd=new data, busy_count unchanged.
6. Registers and scoreboard loaded (busy_count=2); assert reset together with regwrite=1 and rsv_en=1 -> next cycle all rd=0, busy=0, busy_count=0, and the write is discarded.

Source files
------------

// File: rtl/reg_file_pkg.sv
`default_nettype none
// reg_file_pkg: shared defaults and helpers for the parametrised register file.
// Revision: 1.0
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 4;
  localparam int ZERO_ADDR = 0;

  // Smallest r with 2**r >= n; usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// rf_scoreboard: per-register busy bits with reserve/release and a registered busy popcount.
// Revision: 1.0
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int AW       = clog2(DEF_NREGS),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             regwrite,
  input  logic [AW-1:0]    wr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [NREGS-1:0] sb,
  output logic [AW:0]      busy_count
);

  logic [NREGS-1:0] sb_next;
  logic [AW:0]      count_next;

  // Release before reserve, so a same-cycle reserve (the younger producer) wins.
  for (genvar i = 0; i < NREGS; i++) begin : g_sb
    if (ZERO_REG && (i == ZERO_ADDR)) begin : g_zero
      assign sb_next[i] = 1'b0;
    end else begin : g_live
      assign sb_next[i] = (sb[i] & ~(regwrite & (wr == AW'(i))))
                        | (rsv_en & (rsv_addr == AW'(i)));
    end
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      count_next = count_next + {{AW{1'b0}}, sb_next[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb         <= '0;
      busy_count <= '0;
    end else begin
      sb         <= sb_next;
      busy_count <= count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// reg_file_sb: NREGS x WIDTH register file, 2 async reads, 1 sync write, optional bypass, scoreboard.
// Revision: 1.0
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  NREGS    = DEF_NREGS,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    rr1,
  input  logic [AW-1:0]    rr2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic [AW-1:0]    wr,
  input  logic [WIDTH-1:0] wd,
  input  logic             regwrite,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             busy1,
  output logic             busy2,
  output logic [AW:0]      busy_count
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] write_hit;
  logic [NREGS-1:0] sb;

  // The zero register has no storage and never sees a write hit, so it never bypasses.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (ZERO_REG && (i == ZERO_ADDR)) begin : g_zero
      assign write_hit[i] = 1'b0;
      assign regs[i]      = '0;
    end else begin : g_store
      logic [WIDTH-1:0] q;
      assign write_hit[i] = regwrite & (wr == AW'(i));
      always_ff @(posedge clock) begin
        if (reset) begin
          q <= '0;
        end else if (write_hit[i]) begin
          q <= wd;
        end
      end
      assign regs[i] = q;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock      (clock),
    .reset      (reset),
    .regwrite   (regwrite),
    .wr         (wr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .sb         (sb),
    .busy_count (busy_count)
  );

  // Addresses with no matching register fall through to the zero defaults.
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rr1 == AW'(i)) begin
        rd1   = (BYPASS && write_hit[i]) ? wd : regs[i];
        busy1 = sb[i] & ~(BYPASS & write_hit[i]);
      end
      if (rr2 == AW'(i)) begin
        rd2   = (BYPASS && write_hit[i]) ? wd : regs[i];
        busy2 = sb[i] & ~(BYPASS & write_hit[i]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// tb_reg_file_sb: directed and randomized checks of reg_file_sb against a behavioural model.
module tb_reg_file_sb;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Instance A: 4 x 16, bypass on, register 0 hard-wired to zero
  logic [1:0]  rr1, rr2, wr, rsv_addr;
  logic [15:0] wd, rd1, rd2;
  logic        regwrite, rsv_en, busy1, busy2;
  logic [2:0]  busy_count;

  // Instance B: 5 x 16, bypass off, register 0 ordinary, addresses 5..7 out of range
  logic [2:0]  b_rr1, b_rr2, b_wr, b_rsv_addr;
  logic [15:0] b_wd, b_rd1, b_rd2;
  logic        b_regwrite, b_rsv_en, b_busy1, b_busy2;
  logic [3:0]  b_busy_count;

  reg_file_sb dut (
    .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
    .wr(wr), .wd(wd), .regwrite(regwrite), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1), .busy2(busy2), .busy_count(busy_count)
  );

  reg_file_sb #(.WIDTH(16), .NREGS(5), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
    .clock(clock), .reset(reset), .rr1(b_rr1), .rr2(b_rr2), .rd1(b_rd1), .rd2(b_rd2),
    .wr(b_wr), .wd(b_wd), .regwrite(b_regwrite), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .busy1(b_busy1), .busy2(b_busy2), .busy_count(b_busy_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: architectural contents and busy flags as plain arrays
  logic [15:0] ma [8];
  logic [15:0] mb [8];
  bit          sa [8];
  bit          sbm [8];

  function automatic logic [15:0] m_rd(input int nregs, input bit byp, input bit zr, input bit sel_b,
                                       input int addr, input bit we, input int wa, input logic [15:0] wdat);
    if (addr >= nregs || (zr && addr == 0)) return 16'h0;
    if (byp && we && wa == addr) return wdat;
    return sel_b ? mb[addr] : ma[addr];
  endfunction

  function automatic bit m_busy(input int nregs, input bit byp, input bit zr, input bit sel_b,
                                input int addr, input bit we, input int wa);
    bit s;
    if (addr >= nregs || (zr && addr == 0)) return 1'b0;
    s = sel_b ? sbm[addr] : sa[addr];
    return s && !(byp && we && wa == addr);
  endfunction

  function automatic int m_count(input bit sel_b);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += sel_b ? int'(sbm[i]) : int'(sa[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        ma[i] = 16'h0; mb[i] = 16'h0; sa[i] = 1'b0; sbm[i] = 1'b0;
      end
    end else begin
      if (regwrite && wr != 2'd0) ma[wr] = wd;
      if (regwrite) sa[wr] = 1'b0;
      if (rsv_en && rsv_addr != 2'd0) sa[rsv_addr] = 1'b1;
      if (b_regwrite && b_wr < 3'd5) begin
        mb[b_wr] = b_wd;
        sbm[b_wr] = 1'b0;
      end
      if (b_rsv_en && b_rsv_addr < 3'd5) sbm[b_rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    regwrite = 1'b0; rsv_en = 1'b0; b_regwrite = 1'b0; b_rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; regwrite = 1'b1; wr = 2'd1; wd = 16'h3C3C; rsv_en = 1'b1; rsv_addr = 2'd2;
    b_regwrite = 1'b1; b_wr = 3'd3; b_wd = 16'h5A5A;
    tick();
    reset = 1'b0; idle();
    for (int a = 0; a < 4; a++) begin
      rr1 = 2'(a); rr2 = 2'(3 - a); b_rr1 = 3'(a); b_rr2 = 3'(a + 1);
      #1;
      checks++; if (rd1 !== 16'h0) begin failures++; $display("FAIL reset_rd1[%0d]: got %h want 0000", a, rd1); end
      checks++; if (rd2 !== 16'h0) begin failures++; $display("FAIL reset_rd2[%0d]: got %h want 0000", a, rd2); end
      checks++; if ({busy1, busy2} !== 2'b00) begin failures++; $display("FAIL reset_busy[%0d]: got %b want 00", a, {busy1, busy2}); end
      checks++; if (b_rd1 !== 16'h0 || b_rd2 !== 16'h0) begin failures++; $display("FAIL reset_b_rd[%0d]: got %h/%h want 0000/0000", a, b_rd1, b_rd2); end
    end
    checks++; if (busy_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", busy_count); end
    checks++; if (b_busy_count !== 4'd0) begin failures++; $display("FAIL reset_b_count: got %0d want 0", b_busy_count); end
  endtask

  task automatic test_write_read();
    idle();
    regwrite = 1'b1; wr = 2'd1; wd = 16'hA5A5;
    b_regwrite = 1'b1; b_wr = 3'd2; b_wd = 16'h1111;
    tick();
    wr = 2'd2; wd = 16'h1234;
    b_wr = 3'd4; b_wd = 16'hBEEF; b_rr1 = 3'd4;
    #1;
    checks++; if (b_rd1 !== 16'h0) begin failures++; $display("FAIL nobypass_same_cycle: got %h want 0000", b_rd1); end
    tick();
    b_regwrite = 1'b0;
    wr = 2'd3; wd = 16'hFFFF;
    tick();
    regwrite = 1'b0; wr = 2'd2; wd = 16'h0F0F; rr1 = 2'd1; rr2 = 2'd3;
    #1;
    checks++; if (rd1 !== 16'hA5A5) begin failures++; $display("FAIL wr_rd1: got %h want a5a5", rd1); end
    checks++; if (rd2 !== 16'hFFFF) begin failures++; $display("FAIL wr_rd2: got %h want ffff", rd2); end
    tick();
    rr1 = 2'd2; b_rr1 = 3'd4; b_rr2 = 3'd2;
    #1;
    checks++; if (rd1 !== 16'h1234) begin failures++; $display("FAIL wr_disabled: got %h want 1234", rd1); end
    checks++; if (b_rd1 !== 16'hBEEF || b_rd2 !== 16'h1111) begin failures++; $display("FAIL b_wr_rd: got %h/%h want beef/1111", b_rd1, b_rd2); end
  endtask

  task automatic test_zero_reg();
    idle();
    regwrite = 1'b1; wr = 2'd0; wd = 16'hDEAD; rsv_en = 1'b1; rsv_addr = 2'd0; rr1 = 2'd0;
    b_regwrite = 1'b1; b_wr = 3'd0; b_wd = 16'h5555;
    #1;
    checks++; if (rd1 !== 16'h0 || busy1 !== 1'b0) begin failures++; $display("FAIL zero_same_cycle: got %h/%b want 0000/0", rd1, busy1); end
    tick();
    idle(); b_rsv_en = 1'b1; b_rsv_addr = 3'd0; b_rr1 = 3'd0;
    #1;
    checks++; if (rd1 !== 16'h0 || busy1 !== 1'b0) begin failures++; $display("FAIL zero_rd_busy: got %h/%b want 0000/0", rd1, busy1); end
    checks++; if (busy_count !== 3'd0) begin failures++; $display("FAIL zero_count: got %0d want 0", busy_count); end
    checks++; if (b_rd1 !== 16'h5555) begin failures++; $display("FAIL b_r0_storage: got %h want 5555", b_rd1); end
    tick();
    b_rsv_en = 1'b0;
    #1;
    checks++; if (b_busy1 !== 1'b1 || b_busy_count !== 4'd1) begin failures++; $display("FAIL b_r0_busy: got %b/%0d want 1/1", b_busy1, b_busy_count); end
    b_regwrite = 1'b1; b_wr = 3'd0; b_wd = 16'h5555;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    idle();
    regwrite = 1'b1; wr = 2'd2; wd = 16'h00C3; rr1 = 2'd2; rr2 = 2'd2;
    b_regwrite = 1'b1; b_wr = 3'd2; b_wd = 16'h00C3; b_rr1 = 3'd2; b_rr2 = 3'd2;
    #1;
    checks++; if (rd1 !== 16'h00C3 || rd2 !== 16'h00C3) begin failures++; $display("FAIL bypass_both: got %h/%h want 00c3/00c3", rd1, rd2); end
    checks++; if (b_rd1 !== 16'h1111 || b_rd2 !== 16'h1111) begin failures++; $display("FAIL nobypass_old: got %h/%h want 1111/1111", b_rd1, b_rd2); end
    tick();
    idle();
    #1;
    checks++; if (b_rd1 !== 16'h00C3 || rd1 !== 16'h00C3) begin failures++; $display("FAIL bypass_next: got %h/%h want 00c3/00c3", b_rd1, rd1); end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 2'd3; rr1 = 2'd3;
    b_rsv_en = 1'b1; b_rsv_addr = 3'd4; b_rr1 = 3'd4;
    #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rsv_same_cycle: got %b want 0", busy1); end
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b1 || busy_count !== 3'd1) begin failures++; $display("FAIL rsv_busy: got %b/%0d want 1/1", busy1, busy_count); end
    regwrite = 1'b1; wr = 2'd3; wd = 16'h0042;
    b_regwrite = 1'b1; b_wr = 3'd4; b_wd = 16'h0042;
    #1;
    checks++; if (busy1 !== 1'b0 || rd1 !== 16'h0042) begin failures++; $display("FAIL wb_bypass: got %b/%h want 0/0042", busy1, rd1); end
    checks++; if (b_busy1 !== 1'b1 || b_rd1 !== 16'hBEEF) begin failures++; $display("FAIL b_wb_nobypass: got %b/%h want 1/beef", b_busy1, b_rd1); end
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b0 || busy_count !== 3'd0 || rd1 !== 16'h0042) begin failures++; $display("FAIL wb_release: got %b/%0d/%h want 0/0/0042", busy1, busy_count, rd1); end
    checks++; if (b_busy1 !== 1'b0 || b_busy_count !== 4'd0 || b_rd1 !== 16'h0042) begin failures++; $display("FAIL b_wb_release: got %b/%0d/%h want 0/0/0042", b_busy1, b_busy_count, b_rd1); end
  endtask

  task automatic test_write_reserve_same();
    logic [15:0] v;
    v = 16'($urandom);
    idle();
    rsv_en = 1'b1; rsv_addr = 2'd2;
    tick();
    regwrite = 1'b1; wr = 2'd2; wd = v; rr1 = 2'd2;
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b1 || rd1 !== v || busy_count !== 3'd1) begin failures++; $display("FAIL wr_rsv_same: got %b/%h/%0d want 1/%h/1", busy1, rd1, busy_count, v); end
    rsv_en = 1'b1; rsv_addr = 2'd2;
    tick();
    idle();
    #1;
    checks++; if (busy_count !== 3'd1) begin failures++; $display("FAIL rsv_again: got %0d want 1", busy_count); end
    regwrite = 1'b1; wr = 2'd2; wd = v;
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b0 || busy_count !== 3'd0) begin failures++; $display("FAIL wr_rsv_clear: got %b/%0d want 0/0", busy1, busy_count); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] e;
    idle();
    b_regwrite = 1'b1; b_wr = 3'd5; b_wd = 16'($urandom); b_rsv_en = 1'b1; b_rsv_addr = 3'd6;
    b_rr1 = 3'd5; b_rr2 = 3'd7;
    #1;
    checks++; if (b_rd1 !== 16'h0 || b_rd2 !== 16'h0) begin failures++; $display("FAIL oor_rd: got %h/%h want 0000/0000", b_rd1, b_rd2); end
    tick();
    b_wr = 3'd7; b_wd = 16'($urandom); b_rsv_addr = 3'd5;
    tick();
    b_wr = 3'd6; b_wd = 16'($urandom); b_rsv_addr = 3'd7;
    tick();
    idle();
    #1;
    checks++; if (b_busy1 !== 1'b0 || b_busy2 !== 1'b0 || b_busy_count !== 4'd0) begin failures++; $display("FAIL oor_busy: got %b%b/%0d want 00/0", b_busy1, b_busy2, b_busy_count); end
    for (int a = 0; a < 5; a++) begin
      b_rr1 = 3'(a);
      #1;
      e = m_rd(5, 1'b0, 1'b0, 1'b1, a, 1'b0, 0, 16'h0);
      checks++; if (b_rd1 !== e) begin failures++; $display("FAIL oor_alias[%0d]: got %h want %h", a, b_rd1, e); end
    end
  endtask

  task automatic test_reset_priority();
    idle();
    regwrite = 1'b1; wr = 2'd1; wd = 16'h1111; rsv_en = 1'b1; rsv_addr = 2'd1;
    tick();
    wr = 2'd2; wd = 16'h2222; rsv_addr = 2'd2;
    b_rsv_en = 1'b1; b_rsv_addr = 3'd1;
    tick();
    idle();
    #1;
    checks++; if (busy_count !== 3'd2) begin failures++; $display("FAIL load_count: got %0d want 2", busy_count); end
    reset = 1'b1; regwrite = 1'b1; wr = 2'd3; wd = 16'h7777; rsv_en = 1'b1; rsv_addr = 2'd3;
    b_regwrite = 1'b1; b_wr = 3'd4; b_wd = 16'h7777;
    tick();
    reset = 1'b0; idle();
    for (int a = 0; a < 4; a++) begin
      rr1 = 2'(a); rr2 = 2'(3 - a); b_rr1 = 3'(a + 1);
      #1;
      checks++; if (rd1 !== 16'h0 || rd2 !== 16'h0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL rst_prio[%0d]: got %h/%h/%b%b want 0000/0000/00", a, rd1, rd2, busy1, busy2); end
      checks++; if (b_rd1 !== 16'h0 || b_busy1 !== 1'b0) begin failures++; $display("FAIL rst_prio_b[%0d]: got %h/%b want 0000/0", a, b_rd1, b_busy1); end
    end
    checks++; if (busy_count !== 3'd0 || b_busy_count !== 4'd0) begin failures++; $display("FAIL rst_prio_count: got %0d/%0d want 0/0", busy_count, b_busy_count); end
  endtask

  task automatic test_random();
    logic [15:0] e;
    bit eb;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      rr1 = 2'($urandom_range(0, 3)); rr2 = 2'($urandom_range(0, 3));
      wr = 2'($urandom_range(0, 3)); rsv_addr = 2'($urandom_range(0, 3));
      regwrite = 1'($urandom); rsv_en = 1'($urandom); wd = 16'($urandom);
      b_rr1 = 3'($urandom_range(0, 7)); b_rr2 = 3'($urandom_range(0, 7));
      b_wr = 3'($urandom_range(0, 7)); b_rsv_addr = 3'($urandom_range(0, 7));
      b_regwrite = 1'($urandom); b_rsv_en = 1'($urandom); b_wd = 16'($urandom);
      #1;
      e = m_rd(4, 1'b1, 1'b1, 1'b0, int'(rr1), regwrite, int'(wr), wd);
      checks++; if (rd1 !== e) begin failures++; $display("FAIL rand_rd1 n=%0d: got %h want %h", n, rd1, e); end
      e = m_rd(4, 1'b1, 1'b1, 1'b0, int'(rr2), regwrite, int'(wr), wd);
      checks++; if (rd2 !== e) begin failures++; $display("FAIL rand_rd2 n=%0d: got %h want %h", n, rd2, e); end
      eb = m_busy(4, 1'b1, 1'b1, 1'b0, int'(rr1), regwrite, int'(wr));
      checks++; if (busy1 !== eb) begin failures++; $display("FAIL rand_busy1 n=%0d: got %b want %b", n, busy1, eb); end
      eb = m_busy(4, 1'b1, 1'b1, 1'b0, int'(rr2), regwrite, int'(wr));
      checks++; if (busy2 !== eb) begin failures++; $display("FAIL rand_busy2 n=%0d: got %b want %b", n, busy2, eb); end
      checks++; if (int'(busy_count) !== m_count(1'b0)) begin failures++; $display("FAIL rand_count n=%0d: got %0d want %0d", n, busy_count, m_count(1'b0)); end
      e = m_rd(5, 1'b0, 1'b0, 1'b1, int'(b_rr1), b_regwrite, int'(b_wr), b_wd);
      checks++; if (b_rd1 !== e) begin failures++; $display("FAIL rand_b_rd1 n=%0d: got %h want %h", n, b_rd1, e); end
      e = m_rd(5, 1'b0, 1'b0, 1'b1, int'(b_rr2), b_regwrite, int'(b_wr), b_wd);
      checks++; if (b_rd2 !== e) begin failures++; $display("FAIL rand_b_rd2 n=%0d: got %h want %h", n, b_rd2, e); end
      eb = m_busy(5, 1'b0, 1'b0, 1'b1, int'(b_rr1), b_regwrite, int'(b_wr));
      checks++; if (b_busy1 !== eb) begin failures++; $display("FAIL rand_b_busy1 n=%0d: got %b want %b", n, b_busy1, eb); end
      eb = m_busy(5, 1'b0, 1'b0, 1'b1, int'(b_rr2), b_regwrite, int'(b_wr));
      checks++; if (b_busy2 !== eb) begin failures++; $display("FAIL rand_b_busy2 n=%0d: got %b want %b", n, b_busy2, eb); end
      checks++; if (int'(b_busy_count) !== m_count(1'b1)) begin failures++; $display("FAIL rand_b_count n=%0d: got %0d want %0d", n, b_busy_count, m_count(1'b1)); end
      tick();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    rr1 = '0; rr2 = '0; wr = '0; rsv_addr = '0; wd = '0;
    b_rr1 = '0; b_rr2 = '0; b_wr = '0; b_rsv_addr = '0; b_wd = '0;
    idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_write_reserve_same();
    test_out_of_range();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
